// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Requests use a valid/ready handshake; responses are in order with no backpressure.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited in-order imem requests, instruction FIFO, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and raise fetch_misaligned.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  output logic [2:0]      if_funct3,
  output logic [6:0]      if_funct7
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [31:0]     instr_mem [FIFO_DEPTH];

  logic            halted;
  logic [XLEN-1:0] redirect_target;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e state_q;
  logic   misaligned_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state_q      <= ST_HALT;
        misaligned_q <= 1'b1;
      end else begin
        state_q      <= ST_RUN;
        misaligned_q <= 1'b0;
      end
    end
  end

  assign halted           = (state_q == ST_HALT);
  assign fetch_misaligned = misaligned_q;
  assign redirect_target  = redirect_pc;
`else
  assign halted          = 1'b0;
  assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

  // Responses already owed plus buffered words never exceed the FIFO, so a response always fits.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);

  assign imem.imem_req_valid = rst_n && !redirect_valid && !halted && credit_ok;
  assign imem.imem_req_addr  = pc_q;

  assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_drop = (drop_cnt_q != '0);
  assign push     = imem.imem_rsp_valid && !redirect_valid && !rsp_drop && !halted;
  assign pop      = if_valid && if_ready && !redirect_valid;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem.imem_rsp_valid);
    count_d       = count_q + CW'(push) - CW'(pop);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);

    if (req_fire)                          pc_d       = pc_q + XLEN'(4);
    if (imem.imem_rsp_valid && rsp_drop)   drop_cnt_d = drop_cnt_q - CW'(1);
    if (push)                              rsp_pc_d   = rsp_pc_q + XLEN'(4);

    // Redirect overrides everything: no request was issued, so every owed response is wrong-path.
    if (redirect_valid) begin
      pc_d       = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = outstanding_q - CW'(imem.imem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // NOTE: buffer storage is deliberately not reset; outputs are forced to zero while it is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
      instr_mem[wr_ptr_q] <= imem.imem_rsp_data;
    end
  end

  assign if_valid  = (count_q != '0);
  assign if_instr  = if_valid ? instr_mem[rd_ptr_q] : '0;
  assign if_pc     = if_valid ? pc_mem[rd_ptr_q]    : '0;
  assign if_opcode = if_instr[6:0];
  assign if_funct3 = if_instr[14:12];
  assign if_funct7 = if_instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic, all checked
// against a queue-based model of requests in flight and instructions awaiting decode.
module tb_fetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    bit          wanted;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic [2:0]  if_funct3;
  logic [6:0]  if_funct7;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode),
    .if_funct3      (if_funct3),
    .if_funct7      (if_funct7)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state
  logic [31:0] model_pc = 32'h0;
  bit          model_halted = 1'b0;
  flight_t     inflight[$];
  entry_t      exp_q[$];

  // Memory environment: addresses actually requested by the DUT, answered in order
  logic [31:0] mem_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0033;
    if (a == 32'h4) return 32'h0040_0093;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit rdy, input bit rsp_en, input bit ifr,
                       input bit redir, input logic [31:0] rpc);
    bit          exp_rv;
    bit          fire_obs;
    bit          rsp;
    bit          pop;
    logic [31:0] obs_addr;
    flight_t     f;
    entry_t      e;

    rsp = rsp_en && (mem_q.size() > 0);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? data_of(mem_q[0]) : $urandom;
    if_ready           = ifr;
    redirect_valid     = redir;
    redirect_pc        = rpc;
    #4;

    exp_rv = !redir && !model_halted && ((inflight.size() + exp_q.size()) < DEPTH);
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", bus.imem_req_addr, model_pc);
    check("if_valid", 32'(if_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("if_pc",     if_pc,             e.pc);
      check("if_instr",  if_instr,          e.instr);
      check("if_opcode", 32'(if_opcode),    32'(e.instr[6:0]));
      check("if_funct3", 32'(if_funct3),    32'(e.instr[14:12]));
      check("if_funct7", 32'(if_funct7),    32'(e.instr[31:25]));
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misaligned", 32'(fetch_misaligned), 32'(model_halted));
`endif

    fire_obs = bus.imem_req_valid && rdy;
    obs_addr = bus.imem_req_addr;
    pop      = (exp_q.size() > 0) && ifr && !redir;

    if (redir) begin
      exp_q.delete();
      if (rsp && inflight.size() > 0) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].wanted = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      model_pc     = rpc;
      model_halted = (rpc[1:0] != 2'b00);
`else
      model_pc = {rpc[31:2], 2'b00};
`endif
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rsp && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (f.wanted) exp_q.push_back('{pc: f.addr, instr: data_of(f.addr)});
      end
      if (exp_rv && rdy) begin
        inflight.push_back('{addr: model_pc, wanted: 1'b1});
        model_pc = model_pc + 32'd4;
      end
    end

    @(posedge clk);
    if (rsp) void'(mem_q.pop_front());
    if (fire_obs) mem_q.push_back(obs_addr);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] rpc;

    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    if_ready           = 1'b0;

    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_if_valid",  32'(if_valid),           32'h0);
    check("rst_if_instr",  if_instr,                32'h0);
    check("rst_if_pc",     if_pc,                   32'h0);
    check("rst_fields",    32'({if_opcode, if_funct3, if_funct7}), 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misaligned", 32'(fetch_misaligned), 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream from the reset PC with a 1-cycle memory
    run(8);

    // Decode stalls: requests stop at the credit limit, head held stable
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    run(6);

    // Drain, then build up two outstanding requests and redirect over them
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    run(8);

    // Redirect coinciding with a response and a pop
    for (int i = 0; i < 10 && !(mem_q.size() > 0 && exp_q.size() > 0); i++)
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
    run(4);

    // PC wraps past the top of the address space
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    run(8);

`ifdef FETCH_MISALIGN_CHECK_EN
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102);
    run(4);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    run(6);
`else
    // Low target bits are ignored
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102);
    run(6);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
`ifdef FETCH_MISALIGN_CHECK_EN
        1:       rpc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'h3);
`else
        1:       rpc = $urandom;
`endif
        default: rpc = $urandom & ~32'h3;
      endcase
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
